cache_ctrl: RTL and testbench

Read-only, direct-mapped cache controller that sequences the 4-line × 8-byte `cache_multi` datapath. It sits between a byte-wide CPU read port and a byte-serial backing-memory port. It holds tags and valid bits, serves hits from the cache RAM, and refills a whole line on a miss by writing it byte by byte through the RAM's byte-enable write port. It also keeps hit and miss counters.

---
 rtl/cache_pkg.sv | 9 +
 rtl/cache_ctrl_if.sv | 17 +
 rtl/cache_tag_store.sv | 34 +++
 rtl/cache_ctrl.sv | 125 ++++++++++++
 tb/tb_cache_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped read cache.
package cache_pkg;
    localparam int LINES      = 4;
    localparam int LINE_BYTES = 8;
    localparam int OFF_W      = 3;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;
endpackage

// File: rtl/cache_ctrl_if.sv
// CPU read port and byte-serial backing-memory port of the cache controller.
interface cache_ctrl_if #(parameter int ADDR_W = 8);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              inv;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (output cpu_req, cpu_addr, inv, mem_ack, mem_rdata,
                    input  cpu_ack, cpu_rdata, mem_req, mem_addr);
    modport slave  (input  cpu_req, cpu_addr, inv, mem_ack, mem_rdata,
                    output cpu_ack, cpu_rdata, mem_req, mem_addr);
endinterface

// File: rtl/cache_tag_store.sv
// Valid bits and tags for each cache line, with a combinational hit compare.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_all,
    input  logic             set_line,
    input  logic             clr_line,
    input  logic [IDX_W-1:0] idx,
    input  logic [TAG_W-1:0] tag,
    output logic             hit
);
    logic [LINES-1:0]            valid;
    logic [LINES-1:0][TAG_W-1:0] tags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            tags  <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (set_line) begin
            valid[idx] <= 1'b1;
            tags[idx]  <= tag;
        end else if (clr_line) begin
            valid[idx] <= 1'b0;
        end
    end

    assign hit = valid[idx] && (tags[idx] == tag);
endmodule

// File: rtl/cache_ctrl.sv
// Read-only direct-mapped cache controller: FSM, line refill sequencing,
// cache RAM port muxing and saturating hit/miss statistics.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_ctrl_if.slave      bus,
    output logic [IDX_W-1:0] rdline,
    output logic [OFF_W-1:0] rdoffset,
    output logic [IDX_W-1:0] wrline,
    output logic [OFF_W-1:0] wroffset,
    output logic             wren,
    output logic [7:0]       wdata,
    input  logic [7:0]       cache_q,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  beat;
    logic              refill_q, inv_pend, hit;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              clr_all, set_line, clr_line, take_req, beat_ack, last_beat;
    logic [15:0]       hit_nxt, miss_nxt;

    assign tag_q     = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign idx_q     = addr_q[OFF_W +: IDX_W];
    assign beat_ack  = (state == FILL) && bus.mem_ack;
    assign last_beat = beat_ack && (beat == OFF_W'(LINE_BYTES-1));

    cache_tag_store #(.TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_all  (clr_all),
        .set_line (set_line),
        .clr_line (clr_line),
        .idx      (idx_q),
        .tag      (tag_q),
        .hit      (hit)
    );

    always_comb begin
        state_nxt = state;
        clr_all   = 1'b0;
        set_line  = 1'b0;
        clr_line  = 1'b0;
        take_req  = 1'b0;
        hit_nxt   = hit_cnt;
        miss_nxt  = miss_cnt;
        case (state)
            IDLE: begin
                if (bus.inv || inv_pend) begin
                    clr_all = 1'b1;
                end else if (bus.cpu_req) begin
                    take_req  = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    state_nxt = IDLE;
                    // The re-lookup after a refill already counted as a miss.
                    if (!refill_q && hit_cnt != 16'hFFFF) hit_nxt = hit_cnt + 16'd1;
                end else begin
                    clr_line  = 1'b1;
                    state_nxt = FILL;
                    if (miss_cnt != 16'hFFFF) miss_nxt = miss_cnt + 16'd1;
                end
            end
            FILL: begin
                if (last_beat) begin
                    set_line  = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            beat          <= '0;
            refill_q      <= 1'b0;
            inv_pend      <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            hit_cnt     <= hit_nxt;
            miss_cnt    <= miss_nxt;
            bus.cpu_ack <= (state == LOOKUP) && hit;
            if (take_req) addr_q <= bus.cpu_addr;
            if (state == LOOKUP && hit) begin
                bus.cpu_rdata <= cache_q;
                refill_q      <= 1'b0;
            end
            if (set_line) refill_q <= 1'b1;
            if (state == LOOKUP && !hit) beat <= '0;
            else if (beat_ack)           beat <= beat + 1'b1;
            if (state == IDLE)  inv_pend <= 1'b0;
            else if (bus.inv)   inv_pend <= 1'b1;
        end
    end

    // Outside FILL the memory port is parked at zero; reset drops it at once.
    assign bus.mem_req  = (state == FILL);
    assign bus.mem_addr = (state == FILL) ? {addr_q[ADDR_W-1:OFF_W], beat} : '0;

    assign rdline   = idx_q;
    assign rdoffset = addr_q[OFF_W-1:0];
    assign wren     = beat_ack;
    assign wrline   = idx_q;
    assign wroffset = beat;
    assign wdata    = bus.mem_rdata;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a transaction-level cache model predicts
// hit/miss, latency, data and counters; a per-cycle monitor checks the fill port.
module tb_cache_ctrl;
    logic        clk;
    logic        rst_n;
    logic [1:0]  rdline, wrline;
    logic [2:0]  rdoffset, wroffset;
    logic        wren;
    logic [7:0]  wdata, cache_q;
    logic [15:0] hit_cnt, miss_cnt;

    cache_ctrl_if #(.ADDR_W(8)) bus ();

    cache_ctrl #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rdline   (rdline),
        .rdoffset (rdoffset),
        .wrline   (wrline),
        .wroffset (wroffset),
        .wren     (wren),
        .wdata    (wdata),
        .cache_q  (cache_q),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache RAM stand-in clocked on the falling edge.
    logic [7:0] ram [0:31];
    always @(negedge clk) begin
        if (wren) ram[{wrline, wroffset}] <= wdata;
        cache_q <= ram[{rdline, rdoffset}];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory returns addr^0x5A after mem_stall idle cycles per beat.
    int mem_stall = 0;
    int wait_cnt  = 0;
    always @(posedge clk) begin
        #1;
        if (bus.mem_req) begin
            if (wait_cnt >= mem_stall) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = bus.mem_addr ^ 8'h5A;
                wait_cnt      = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Model state
    logic [3:0]  m_valid;
    logic [2:0]  m_tag [4];
    logic [15:0] m_hits, m_misses;
    logic [7:0]  fill_base;
    int          beat_exp, beats_seen;
    logic [7:0]  last_rdata;
    int          last_lat;

    // Per-cycle fill-port monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_req) begin
                check("mem_addr", bus.mem_addr, fill_base + beat_exp);
                check("wren_fill", wren, bus.mem_ack);
                if (bus.mem_ack) begin
                    check("wrline", wrline, fill_base[4:3]);
                    check("wroffset", wroffset, beat_exp[2:0]);
                    check("wdata", wdata, (fill_base + beat_exp) ^ 8'h5A);
                    beat_exp++;
                    beats_seen++;
                end
            end else begin
                check("wren_idle", wren, 0);
            end
        end
    end

    task automatic do_read(input logic [7:0] a, input int stall, input bit inv_first, input int inv_at);
        logic [1:0] idx;
        logic [2:0] tg;
        bit         hit, got;
        int         exp_lat, cyc;
        idx = a[4:3];
        tg  = a[7:5];
        if (inv_first) m_valid = '0;
        hit     = m_valid[idx] && (m_tag[idx] == tg);
        exp_lat = hit ? 2 : 3 + 8 * (stall + 1);
        if (inv_first) exp_lat++;
        mem_stall  = stall;
        fill_base  = {a[7:3], 3'b000};
        beat_exp   = 0;
        beats_seen = 0;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        bus.inv      = inv_first;
        cyc = 0;
        got = 0;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            bus.inv = (inv_at != 0 && cyc == inv_at);
            @(negedge clk);
            if (bus.cpu_ack) got = 1;
        end
        bus.cpu_req = 1'b0;
        bus.inv     = 1'b0;
        check("ack_seen", got, 1);
        check("latency", cyc, exp_lat);
        check("rdata", bus.cpu_rdata, a ^ 8'h5A);
        check("beats", beats_seen, hit ? 0 : 8);
        if (hit) begin
            if (m_hits != 16'hFFFF) m_hits++;
        end else begin
            if (m_misses != 16'hFFFF) m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
        if (inv_at != 0) m_valid = '0;
        last_rdata = bus.cpu_rdata;
        last_lat   = cyc;
    endtask

    task automatic reset_mid_fill(input logic [7:0] a);
        int cyc;
        mem_stall  = 0;
        fill_base  = {a[7:3], 3'b000};
        beat_exp   = 0;
        beats_seen = 0;
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        cyc = 0;
        while (beats_seen < 4 && cyc < 100) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("rst_beats", beats_seen, 4);
        rst_n       = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_wren", wren, 0);
        check("rst_cpu_ack", bus.cpu_ack, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        m_valid  = '0;
        m_hits   = '0;
        m_misses = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_addr  = '0;
        bus.inv       = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        m_valid       = '0;
        m_hits        = '0;
        m_misses      = '0;
        fill_base     = '0;
        beat_exp      = 0;
        beats_seen    = 0;
        #2 rst_n = 1'b0;
        #20;
        check("reset_cpu_ack", bus.cpu_ack, 0);
        check("reset_cpu_rdata", bus.cpu_rdata, 0);
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_wren", wren, 0);
        check("reset_hit_cnt", hit_cnt, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold miss, then hit on the same line
        do_read(8'h2B, 0, 0, 0);
        check("lit_cold_rdata", last_rdata, 8'h71);
        check("lit_cold_lat", last_lat, 11);
        check("lit_cold_miss", miss_cnt, 1);
        check("lit_cold_hit", hit_cnt, 0);
        do_read(8'h2E, 0, 0, 0);
        check("lit_hit_rdata", last_rdata, 8'h74);
        check("lit_hit_lat", last_lat, 2);
        check("lit_hit_cnt", hit_cnt, 1);

        // Conflict on line 1
        do_read(8'h4B, 0, 0, 0);
        do_read(8'h2B, 0, 0, 0);
        check("lit_conflict_miss", miss_cnt, 3);

        // Invalidate together with a request, then a deferred invalidate
        do_read(8'h48, 0, 0, 0);
        do_read(8'h49, 0, 0, 0);
        do_read(8'h48, 0, 1, 0);
        check("lit_inv_lat", last_lat, 12);
        do_read(8'h10, 0, 0, 5);
        do_read(8'h10, 0, 0, 0);
        check("lit_deferred_miss", miss_cnt, 7);

        // Stalled memory
        do_read(8'h60, 3, 0, 0);
        check("lit_stall_lat", last_lat, 35);
        do_read(8'h61, 0, 0, 0);

        // Reset mid-fill, then the line refetches in full
        reset_mid_fill(8'h18);
        do_read(8'h18, 0, 0, 0);
        check("lit_refetch_miss", miss_cnt, 1);

        // Saturation: preload the hit counter just below its ceiling
        force dut.hit_cnt = 16'hFFFE;
        @(posedge clk);
        @(posedge clk); #1;
        release dut.hit_cnt;
        m_hits = 16'hFFFE;
        do_read(8'h19, 0, 0, 0);
        do_read(8'h1A, 0, 0, 0);
        do_read(8'h1F, 0, 0, 0);
        check("lit_sat", hit_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
